req_encoder_16: RTL
===================

REQ_ENCODER_16 -- requirements
Module: req_encoder_16

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 en_i  input  1  request-capture enable; 0 = req_i ignored that cycle.
REQ-004 clr_i  input  1  synchronous flush of all pending and presented requests.
REQ-005 req_i  input  16  multi-hot request vector; bit k requests service of index k.
REQ-006 valid_o  output  1  code_o holds a served index.
REQ-007 ready_i  input  1  consumer accepts code_o; transfer when valid_o && ready_i.
REQ-008 code_o  output  4  binary index of presented request.
REQ-009 pend_o  output  16  pending-request mask, not including the presented index.
REQ-010 cnt_o  output  5  population count of pend_o, 0..16.

Function
REQ-011 Block SHALL hold two state elements: pending mask P[15:0] and output stage {valid_o, code_o}.
REQ-012 Output stage SHALL be a two-state FSM: EMPTY (valid_o=0), FULL (valid_o=1).
REQ-013 Each cycle: take = EMPTY or (valid_o && ready_i); cand = P | (en_i ? req_i : 0).
REQ-014 If take and cand != 0: code_o <= highest set index of cand; valid_o <= 1; P <= cand with that bit cleared.
REQ-015 If take and cand == 0: valid_o <= 0 (FSM -> EMPTY); P <= 0.
REQ-016 If not take: code_o and valid_o SHALL hold unchanged; P <= cand.
REQ-017 Priority SHALL be fixed, index 15 highest, index 0 lowest; lower indices may starve.
REQ-018 Latency: req_i bit sampled at edge N with output EMPTY SHALL appear on code_o/valid_o after edge N.
REQ-019 Throughput SHALL be one code per cycle while ready_i=1 and cand != 0.
REQ-020 Request for the index currently on code_o SHALL NOT merge with it; it enters P and is served again later.
REQ-021 Request for an index already in P SHALL merge (OR), no duplicate service.
REQ-022 clr_i=1 SHALL set P <= 0, valid_o <= 0, code_o <= 0 at next edge; clr_i wins over same-cycle req_i and handshake.
REQ-023 code_o SHALL be 0 whenever valid_o=0.
REQ-024 pend_o SHALL equal P; cnt_o SHALL equal popcount(P), both registered-state derived, combinational from P.
REQ-025 Every index captured SHALL be presented exactly once unless removed by clr_i or reset.

Reset
REQ-026 rst_n=0 SHALL immediately force P=0, valid_o=0, code_o=0, FSM=EMPTY, hence pend_o=0, cnt_o=0.
REQ-027 Reset mid-transfer SHALL discard the presented and all pending requests; no replay after release.
REQ-028 First capture after reset deassertion SHALL occur at the first rising edge with rst_n=1.

Structure
REQ-029 Shared package SHALL hold N_REQ=16, CODE_W=4, CNT_W=5 and the output FSM state enum {EMPTY, FULL}.
REQ-030 One sub-module prio_enc16 SHALL implement combinational highest-set-index plus any-set flag; top instantiates it once on cand.
REQ-031 One-hot clear mask for the served index SHALL be derived in the top from the encoder output.

Verification
REQ-032 Reset, en_i=1, req_i=16'h8001 one cycle, ready_i=1 -> code_o 15 then 0 on consecutive cycles, then valid_o=0, cnt_o=0.
REQ-033 req_i=16'h00F0 one cycle, ready_i=0 for 5 cycles -> code_o=7 held stable, pend_o=16'h0070, cnt_o=3; then ready_i=1 -> 6,5,4.
REQ-034 code_o=3 presented with ready_i=0, req_i=16'h0008 -> pend_o=16'h0008; after handshake code_o=3 again.
REQ-035 en_i=0, req_i=16'hFFFF -> valid_o stays 0, pend_o stays 0.
REQ-036 P=16'h0F00, valid_o=1, same cycle clr_i=1, req_i=16'h0001, ready_i=1 -> next cycle valid_o=0, pend_o=0.
REQ-037 rst_n pulsed low mid-cycle with P=16'hFFFF, valid_o=1 -> outputs zero without clock edge; after release no output until new req_i.

Source files
------------

// File: rtl/req_encoder_16_pkg.sv
// Shared definitions for the 16-input request encoder.
// Holds the request/code/count widths, the output-stage state type and a
// population-count helper used to derive cnt_o from the pending mask.
package req_encoder_16_pkg;

  localparam int N_REQ  = 16;
  localparam int CODE_W = 4;
  localparam int CNT_W  = 5;

  // Output stage: EMPTY means nothing is presented, FULL means code_o is valid.
  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  function automatic logic [CNT_W-1:0] popcount16(input logic [N_REQ-1:0] mask);
    logic [CNT_W-1:0] sum;
    sum = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = sum + CNT_W'(mask[k]);
    end
    return sum;
  endfunction

endpackage

// File: rtl/req_encoder_16_prio_enc16.sv
// Fixed-priority encoder, purely combinational.
// Ports:
//   i_vec : 16-bit multi-hot input vector
//   o_idx : index of the highest set bit (0 when nothing is set)
//   o_any : 1 when at least one bit of i_vec is set
module prio_enc16
  import req_encoder_16_pkg::*;
(
  input  logic [N_REQ-1:0]  i_vec,
  output logic [CODE_W-1:0] o_idx,
  output logic              o_any
);

  // Scan upward so the last set bit found, i.e. the highest index, wins.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (i_vec[k]) begin
        o_idx = CODE_W'(k);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_encoder_16.sv
// Request encoder with a pending mask and a one-entry output stage.
// Requests are accumulated into a pending mask; whenever the output stage
// can take a new entry, the highest-numbered candidate is presented as a
// binary code and removed from the mask.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   en_i     : request-capture enable
//   clr_i    : synchronous flush of pending and presented requests
//   req_i    : 16-bit multi-hot request vector
//   ready_i  : consumer accepts code_o this cycle
//   valid_o  : code_o holds a served index
//   code_o   : presented index (0 when not valid)
//   pend_o   : pending mask, excluding the presented index
//   cnt_o    : number of pending requests
module req_encoder_16
  import req_encoder_16_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic [N_REQ-1:0]  req_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [CODE_W-1:0] code_o,
  output logic [N_REQ-1:0]  pend_o,
  output logic [CNT_W-1:0]  cnt_o
);

  out_state_e        r_state;
  logic [CODE_W-1:0] r_code;
  logic [N_REQ-1:0]  r_pend;

  logic [N_REQ-1:0]  w_cand;
  logic              w_take;
  logic [CODE_W-1:0] w_idx;
  logic              w_any;
  logic [N_REQ-1:0]  w_clrMask;

  // The presented index is not part of r_pend, so a fresh request for it
  // lands in the mask and gets served a second time later.
  assign w_cand = r_pend | (en_i ? req_i : '0);

  // The output stage can load when it is empty or is being drained now.
  assign w_take = (r_state == EMPTY) || ready_i;

  prio_enc16 u_prio (
    .i_vec (w_cand),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_clrMask = {{(N_REQ-1){1'b0}}, 1'b1} << w_idx;

  // Flush has priority over both capture and handshake. A load with no
  // candidate empties the stage and zeroes the code so code_o reads 0
  // whenever valid_o is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_code  <= '0;
      r_pend  <= '0;
    end else if (clr_i) begin
      r_state <= EMPTY;
      r_code  <= '0;
      r_pend  <= '0;
    end else if (w_take) begin
      if (w_any) begin
        r_state <= FULL;
        r_code  <= w_idx;
        r_pend  <= w_cand & ~w_clrMask;
      end else begin
        r_state <= EMPTY;
        r_code  <= '0;
        r_pend  <= '0;
      end
    end else begin
      r_pend <= w_cand;
    end
  end

  assign valid_o = (r_state == FULL);
  assign code_o  = r_code;
  assign pend_o  = r_pend;
  assign cnt_o   = popcount16(r_pend);

endmodule
